keycode_event_queue: RTL and testbench

Downstream consumer of the 8-bit keycode PIO output written by the NIOS II USB-keyboard driver. Converts the level-style "current keycode" value into discrete PRESS / RELEASE / REPEAT events with typematic auto-repeat. Events are buffered in a small FIFO so game/motion logic can drain them with a valid/ready handshake, without sampling the raw keycode at the right moment.

---
 rtl/keycode_event_queue_pkg.sv | 34 +++
 rtl/keycode_event_queue_if.sv | 32 +++
 rtl/keycode_evt_fifo.sv | 74 +++++++
 rtl/keycode_event_queue.sv | 158 +++++++++++++++
 tb/tb_keycode_event_queue.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/keycode_event_queue_pkg.sv
// Shared types for the keycode event queue.
//   evt_type_t  : kind of key event (PRESS / RELEASE / REPEAT)
//   key_evt_t   : one queued event, keycode plus kind
//   fsm_state_t : keycode tracker states
//   KEY_NONE    : keycode value meaning "no key pressed"
package keycode_evt_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_type_t;

  typedef struct packed {
    logic [7:0] code;
    evt_type_t  etype;
  } key_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_SWAP
  } fsm_state_t;

  function automatic key_evt_t mk_evt(input logic [7:0] code, input evt_type_t etype);
    key_evt_t e;
    e.code  = code;
    e.etype = etype;
    return e;
  endfunction

endpackage

// File: rtl/keycode_event_queue_if.sv
// Event output channel of the keycode event queue.
//   evt_valid : head event presented (queue non-empty)
//   evt_ready : consumer takes the head event this cycle
//   evt_code  : keycode of the head event
//   evt_type  : 0 = PRESS, 1 = RELEASE, 2 = REPEAT
//   evt_count : number of events currently queued
// master = the queue, slave = the consumer.
interface keycode_event_queue_if #(
  parameter int DEPTH = 8
);
  logic                         evt_valid;
  logic                         evt_ready;
  logic [7:0]                   evt_code;
  logic [1:0]                   evt_type;
  logic [$clog2(DEPTH+1)-1:0]   evt_count;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_type,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_type,
    input  evt_count,
    output evt_ready
  );
endinterface

// File: rtl/keycode_evt_fifo.sv
// Synchronous show-ahead FIFO of key_evt_t entries.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en_i    : write request; accepted when not full or when a read fires
//   wr_data_i  : event to write
//   rd_en_i    : read request; only fires while non-empty
//   rd_data_o  : head entry, all zeros while empty
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
//   count_o    : number of entries stored
module keycode_evt_fifo
  import keycode_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  key_evt_t                   wr_data_i,
  input  logic                       rd_en_i,
  output key_evt_t                   rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  key_evt_t             mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 rd_fire;
  logic                 wr_fire;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // A read on a full FIFO frees the head slot in the same edge, so the
  // write may land even though full_o is high.
  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

  // NOTE: storage is deliberately left out of reset; stale entries are never
  // visible because the head is masked to zero whenever count_q is zero.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the level-style keycode from the keyboard PIO into discrete
// PRESS / RELEASE / REPEAT events with typematic auto-repeat, buffered in
// a show-ahead FIFO drained over a valid/ready channel.
//   clk, reset     : clock, asynchronous active-high reset
//   keycode_in     : current keycode, 0x00 = no key
//   clear_overflow : synchronous clear of overflow (a new drop wins)
//   overflow       : sticky, an event was dropped on a full queue
//   evt_if         : event channel (valid/ready, code, type, count)
module keycode_event_queue
  import keycode_evt_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             keycode_in,
  input  logic                   clear_overflow,
  output logic                   overflow,
  keycode_event_queue_if.master  evt_if
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(CNT_MAX);

  fsm_state_t        state_q;
  logic [7:0]        key_q;
  logic [7:0]        pend_q;
  logic [RPT_W-1:0]  cnt_q;
  logic              first_q;
  logic              overflow_q;

  logic [RPT_W-1:0]  rpt_term;
  logic              push;
  key_evt_t          push_evt;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  key_evt_t          head;

  // First repeat waits the long delay, later ones the short period.
  assign rpt_term = first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

  // Event generation is combinational so the event is written on the same
  // edge that the tracker state advances.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    push     = 1'b0;
    push_evt = mk_evt(KEY_NONE, EVT_PRESS);
    case (state_q)
      ST_IDLE: begin
        if (keycode_in != KEY_NONE) begin
          push     = 1'b1;
          push_evt = mk_evt(keycode_in, EVT_PRESS);
        end
      end
      ST_HELD: begin
        if (keycode_in == key_q) begin
          if (cnt_q == rpt_term) begin
            push     = 1'b1;
            push_evt = mk_evt(key_q, EVT_REPEAT);
          end
        end else begin
          push     = 1'b1;
          push_evt = mk_evt(key_q, EVT_RELEASE);
        end
      end
      ST_SWAP: begin
        push     = 1'b1;
        push_evt = mk_evt(pend_q, EVT_PRESS);
      end
      default: begin
        push     = 1'b0;
        push_evt = mk_evt(KEY_NONE, EVT_PRESS);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= KEY_NONE;
      pend_q  <= KEY_NONE;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (keycode_in != KEY_NONE) begin
            key_q   <= keycode_in;
            cnt_q   <= '0;
            first_q <= 1'b1;
            state_q <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (keycode_in == key_q) begin
            if (cnt_q == rpt_term) begin
              cnt_q   <= '0;
              first_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (keycode_in == KEY_NONE) begin
            key_q   <= KEY_NONE;
            state_q <= ST_IDLE;
          end else begin
            // RELEASE of the old key goes out now, PRESS of the new one next cycle.
            pend_q  <= keycode_in;
            state_q <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          key_q   <= pend_q;
          cnt_q   <= '0;
          first_q <= 1'b1;
          state_q <= ST_HELD;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop = evt_if.evt_ready && !fifo_empty;

  // Events are lost rather than stalling the tracker; a new drop outranks clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  keycode_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (push_evt),
    .rd_en_i   (evt_if.evt_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (evt_if.evt_count)
  );

  assign evt_if.evt_valid = !fifo_empty;
  assign evt_if.evt_code  = head.code;
  assign evt_if.evt_type  = head.etype;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Self-checking bench for keycode_event_queue: directed scenarios followed by
// random key/ready traffic, all compared every cycle against an event-level
// reference model (held key + elapsed time since PRESS, bounded queue).
module tb_keycode_event_queue;

  localparam int DEPTH = 4;
  localparam int RD    = 10;
  localparam int RP    = 4;

  localparam logic [1:0] K_PRESS   = 2'd0;
  localparam logic [1:0] K_RELEASE = 2'd1;
  localparam logic [1:0] K_REPEAT  = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode_in;
  logic       clear_overflow;
  logic       overflow;

  keycode_event_queue_if #(.DEPTH(DEPTH)) evt_if ();

  keycode_event_queue #(
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .keycode_in     (keycode_in),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .evt_if         (evt_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] code;
    logic [1:0] kind;
  } mevt_t;

  mevt_t q[$];
  int    m_key;      // key currently considered held, 0 = none
  int    m_pend;     // key whose PRESS is still owed after a swap, 0 = none
  int    m_press;    // edge index of the most recent PRESS
  bit    m_ovf;
  int    edge_n = 0;

  task automatic model_reset();
    q.delete();
    m_key   = 0;
    m_pend  = 0;
    m_press = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge(input logic [7:0] kc, input logic rdy, input logic clr);
    bit    has;
    bit    pop;
    bit    drop;
    mevt_t e;
    int    el;
    has  = 0;
    drop = 0;
    e.code = 8'h00;
    e.kind = K_PRESS;
    if (m_pend != 0) begin
      has = 1; e.code = 8'(m_pend); e.kind = K_PRESS;
      m_key = m_pend; m_pend = 0; m_press = edge_n;
    end else if (m_key == 0) begin
      if (kc != 0) begin
        has = 1; e.code = kc; e.kind = K_PRESS;
        m_key = kc; m_press = edge_n;
      end
    end else if (int'(kc) == m_key) begin
      el = edge_n - m_press;
      if (el >= RD && ((el - RD) % RP) == 0) begin
        has = 1; e.code = 8'(m_key); e.kind = K_REPEAT;
      end
    end else if (kc == 0) begin
      has = 1; e.code = 8'(m_key); e.kind = K_RELEASE;
      m_key = 0;
    end else begin
      has = 1; e.code = 8'(m_key); e.kind = K_RELEASE;
      m_pend = kc;
    end

    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (has) begin
      if (q.size() < DEPTH) q.push_back(e);
      else                  drop = 1;
    end
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // ---------------- compare ----------------
  task automatic compare_outputs();
    logic        ev;
    logic [7:0]  ec;
    logic [1:0]  et;
    ev = (q.size() != 0);
    ec = ev ? q[0].code : 8'h00;
    et = ev ? q[0].kind : 2'd0;
    check($sformatf("valid@%0d", edge_n), 32'(evt_if.evt_valid), 32'(ev));
    check($sformatf("code@%0d",  edge_n), 32'(evt_if.evt_code),  32'(ec));
    check($sformatf("type@%0d",  edge_n), 32'(evt_if.evt_type),  32'(et));
    check($sformatf("count@%0d", edge_n), 32'(evt_if.evt_count), 32'(q.size()));
    check($sformatf("ovf@%0d",   edge_n), 32'(overflow),         32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(keycode_in, evt_if.evt_ready, clear_overflow);
    edge_n++;
    #1;
    compare_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'h04;
      2:       return 8'h1A;
      3:       return 8'h2C;
      default: return 8'hFF;
    endcase
  endfunction

  initial begin
    reset            = 1'b1;
    keycode_in       = 8'h00;
    clear_overflow   = 1'b0;
    evt_if.evt_ready = 1'b1;
    model_reset();
    #1;
    compare_outputs();
    ticks(2);
    reset = 1'b0;

    // Press / release
    keycode_in = 8'h04; ticks(6);
    keycode_in = 8'h00; ticks(3);

    // Swap A -> B
    keycode_in = 8'h1A; ticks(3);
    keycode_in = 8'h07; ticks(3);
    keycode_in = 8'h00; ticks(2);

    // Auto-repeat
    keycode_in = 8'h2C; ticks(26);
    keycode_in = 8'h00; ticks(2);

    // Overflow: 6 events into a 4-deep queue, then drain and clear
    evt_if.evt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      keycode_in = 8'h11 + 8'(k); tick();
      keycode_in = 8'h00;         tick();
    end
    evt_if.evt_ready = 1'b1; ticks(5);
    clear_overflow = 1'b1; tick();
    clear_overflow = 1'b0; tick();

    // Full queue with simultaneous push and pop
    evt_if.evt_ready = 1'b0;
    keycode_in = 8'h21; tick();
    keycode_in = 8'h00; tick();
    keycode_in = 8'h22; tick();
    keycode_in = 8'h00; tick();
    keycode_in = 8'h23; evt_if.evt_ready = 1'b1; tick();
    evt_if.evt_ready = 1'b0; tick();
    evt_if.evt_ready = 1'b1; keycode_in = 8'h00; ticks(6);

    // Reset while a key is held with events queued
    evt_if.evt_ready = 1'b0;
    keycode_in = 8'h09; tick();
    keycode_in = 8'h16; tick();
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    ticks(2);
    reset = 1'b0;
    evt_if.evt_ready = 1'b1;
    ticks(16);
    keycode_in = 8'h00; ticks(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) keycode_in = pick_key();
      evt_if.evt_ready = ($urandom_range(0, 9) < 6);
      clear_overflow   = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
